// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative 32x32 -> 64-bit shift-add multiplier.
//
// One 33-bit adder is shared across 32 iterations, one multiplier bit per
// cycle. Signed operands are converted to magnitudes in PREP. The product
// is sign-corrected in FIXUP.
// Operation timeline, with the start accepted at edge E0:
//   E1       PREP -> ITER
//   E2..E33  iterations
//   E34      FIXUP -> DONE; result registers load
//
// Optional feature: define MULT_SEQ_OVF_EN to compute a 32-bit overflow
// flag, which is registered in FIXUP. Without it, ovf is tied low.

module mult_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        ready,
  output logic        done,
  output logic [31:0] resultHigh,
  output logic [31:0] resultLow,
  output logic        ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Magnitude of a 32-bit operand. In signed mode, a negative value is
  // replaced by its two's complement. 0x80000000 maps to 2^31, which still
  // fits in an unsigned 32-bit word.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) begin
      mag32 = (~x) + 32'd1;
    end else begin
      mag32 = x;
    end
  endfunction

  // 64-bit two's-complement negation.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = (~x) + 64'd1;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [31:0] op_a_r;      // captured multiplicand
  logic [31:0] op_b_r;      // captured multiplier
  logic        op_sgn_r;    // captured is_signed
  logic [31:0] a_mag_r;     // |A|
  logic        sign_r;      // sign of the final product
  logic [63:0] prod_r;      // {upper accumulator, remaining multiplier bits}
  logic [5:0]  cnt_r;       // iteration counter

  logic        ready_r;
  logic        done_r;
  logic [31:0] res_hi_r;
  logic [31:0] res_lo_r;

  logic [32:0] add_s;       // upper accumulator plus conditional |A|, with carry
  logic [63:0] fix_s;       // sign-corrected product

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only looked at in the ready states
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = PREP;
        end else begin
          next_state_s = IDLE;
        end
      end
      PREP: begin
        next_state_s = ITER;
      end
      ITER: begin
        if (cnt_r == 6'd31) begin
          next_state_s = FIXUP;
        end else begin
          next_state_s = ITER;
        end
      end
      FIXUP: begin
        next_state_s = DONE;
      end
      DONE: begin
        if (start) begin
          next_state_s = PREP;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Shared adder and the sign fix-up of the finished product
  always_comb begin
    add_s = {1'b0, prod_r[63:32]} + ({33{prod_r[0]}} & {1'b0, a_mag_r});
    if (sign_r) begin
      fix_s = neg64(prod_r);
    end else begin
      fix_s = prod_r;
    end
  end

  // Operand capture, shift-add datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_r   <= 32'd0;
      op_b_r   <= 32'd0;
      op_sgn_r <= 1'b0;
      a_mag_r  <= 32'd0;
      sign_r   <= 1'b0;
      prod_r   <= 64'd0;
      cnt_r    <= 6'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            op_a_r   <= multiplicand;
            op_b_r   <= multiplier;
            op_sgn_r <= is_signed;
          end else begin
            op_a_r   <= op_a_r;
            op_b_r   <= op_b_r;
            op_sgn_r <= op_sgn_r;
          end
        end
        PREP: begin
          a_mag_r <= mag32(op_a_r, op_sgn_r);
          prod_r  <= {32'd0, mag32(op_b_r, op_sgn_r)};
          sign_r  <= op_sgn_r & (op_a_r[31] ^ op_b_r[31]);
          cnt_r   <= 6'd0;
        end
        ITER: begin
          // Add-then-shift: the carry lands in bit 63 after the shift.
          prod_r <= {add_s, prod_r[31:1]};
          cnt_r  <= cnt_r + 6'd1;
        end
        FIXUP: begin
          prod_r   <= fix_s;
          res_hi_r <= fix_s[63:32];
          res_lo_r <= fix_s[31:0];
        end
        default: begin
          prod_r <= prod_r;
        end
      endcase
    end
  end

  // Handshake flags registered from the next state, so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (next_state_s == IDLE) || (next_state_s == DONE);
      done_r  <= (next_state_s == DONE);
    end
  end

`ifdef MULT_SEQ_OVF_EN
  logic ovf_r;

  // Overflow: result does not fit in 32 bits for the selected signedness
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (state_r == FIXUP) begin
      if (op_sgn_r) begin
        ovf_r <= (fix_s[63:32] != {32{fix_s[31]}});
      end else begin
        ovf_r <= (fix_s[63:32] != 32'd0);
      end
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign ready      = ready_r;
  assign done       = done_r;
  assign resultHigh = res_hi_r;
  assign resultLow  = res_lo_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed-vector bench for mult_seq_ctrl.
// Expected products are hand-computed constants. Expected ovf follows
// MULT_SEQ_OVF_EN.

module tb_mult_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        ready;
  logic        done;
  logic [31:0] resultHigh;
  logic [31:0] resultLow;
  logic        ovf;

  int          vec_cnt;
  int          miscmp_cnt;
  logic [63:0] last_res;   // expected result currently held by the DUT

  mult_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .resultHigh   (resultHigh),
    .resultLow    (resultLow),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected ovf for the current build
  function automatic logic ovf_exp(input logic v);
`ifdef MULT_SEQ_OVF_EN
    ovf_exp = v;
`else
    ovf_exp = 1'b0;
`endif
  endfunction

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run one full operation from a ready state and check its timeline
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_res, input logic exp_ovf);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    start        = 1'b1;
    step(1);                                   // E0: accepted
    start        = 1'b0;
    multiplicand = ~a;                         // must not disturb the operation
    multiplier   = 32'hDEAD_BEEF;
    is_signed    = ~s;
    chk({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy"}, {63'd0, ready}, 64'd0);
    chk({tag, "_hold_e0"}, {resultHigh, resultLow}, last_res);
    step(20);                                  // E20, mid-ITER
    chk({tag, "_hold_iter"}, {resultHigh, resultLow}, last_res);
    step(13);                                  // E33
    chk({tag, "_done_e33"}, {63'd0, done}, 64'd0);
    step(1);                                   // E34
    chk({tag, "_done_e34"}, {63'd0, done}, 64'd1);
    chk({tag, "_ready_e34"}, {63'd0, ready}, 64'd1);
    chk({tag, "_result"}, {resultHigh, resultLow}, exp_res);
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, ovf_exp(exp_ovf)});
    last_res = exp_res;
  endtask

  initial begin
    logic saw_done;
    vec_cnt      = 0;
    miscmp_cnt   = 0;
    last_res     = 64'd0;
    reset        = 1'b1;
    start        = 1'b1;    // start during reset must lose to reset
    is_signed    = 1'b0;
    multiplicand = 32'd1;
    multiplier   = 32'd1;
    step(3);
    start = 1'b0;
    step(1);
    reset = 1'b0;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {resultHigh, resultLow}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    step(2);
    chk("idle_ready", {63'd0, ready}, 64'd1);

    run_op("umax",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    step(3);
    chk("umax_done_hold", {63'd0, done}, 64'd1);
    chk("umax_res_hold", {resultHigh, resultLow}, 64'hFFFF_FFFE_0000_0001);
    run_op("sneg1x7", 32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    run_op("sminsq",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
    run_op("snegneg", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_000F, 1'b0);
    run_op("smaxsq",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 1'b1);
    run_op("u2p31x2", 32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, 1'b1);

    // Start while busy: second request at E10 must be ignored
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    is_signed    = 1'b0;
    start        = 1'b1;
    step(1);                                   // E0
    start = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      if (i == 10) begin
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
      end
      step(1);                                 // Ei
      start = 1'b0;
      chk($sformatf("busy_ready_e%0d", i), {63'd0, ready}, (i == 34) ? 64'd1 : 64'd0);
      if (i == 33 || i == 34) begin
        chk($sformatf("busy_done_e%0d", i), {63'd0, done}, (i == 34) ? 64'd1 : 64'd0);
      end
    end
    chk("busy_result", {resultHigh, resultLow}, 64'h0000_0000_0000_000F);
    step(4);
    chk("busy_done_hold", {63'd0, done}, 64'd1);
    chk("busy_res_hold", {resultHigh, resultLow}, 64'h0000_0000_0000_000F);

    // Reset in the middle of ITER aborts the operation
    multiplicand = 32'h11;
    multiplier   = 32'h22;
    start        = 1'b1;
    step(1);                                   // E0
    start = 1'b0;
    step(19);                                  // E19
    reset = 1'b1;
    step(1);                                   // E20
    reset = 1'b0;
    chk("mrst_ready", {63'd0, ready}, 64'd1);
    chk("mrst_done", {63'd0, done}, 64'd0);
    chk("mrst_result", {resultHigh, resultLow}, 64'd0);
    chk("mrst_ovf", {63'd0, ovf}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      saw_done = saw_done | done;
    end
    chk("mrst_no_done", {63'd0, saw_done}, 64'd0);
    last_res = 64'd0;
    run_op("post_rst", 32'd2, 32'd3, 1'b0, 64'h0000_0000_0000_0006, 1'b0);

    // Back-to-back from DONE with a zero multiplicand
    run_op("b2b_zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
